// File: rtl/p2p_link_pkg.sv
// Shared definitions for the 4-bit point-to-point node link (used by both RX and TX).
package p2p_link_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic [NIBBLE_W-1:0] SOF = 4'hA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Running parity: fold one more data nibble into the accumulated XOR
    function automatic logic [NIBBLE_W-1:0] nib_parity(
        input logic [NIBBLE_W-1:0] acc,
        input logic [NIBBLE_W-1:0] nib
    );
        return acc ^ nib;
    endfunction

endpackage

// File: rtl/p2p_rx_fifo.sv
// First-word-fall-through word FIFO; count distinguishes full from empty.
module p2p_rx_fifo
    import p2p_link_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A push into a full FIFO is honoured only when a pop frees the slot on the same edge
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/p2p_link_rx.sv
// Receive side of the 4-bit P2P link: deframes nibbles into words, buffers them,
// and returns one credit per word drained. Parity nibble enabled by P2P_RX_PARITY_EN.
module p2p_link_rx
    import p2p_link_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NIBBLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NIBBLE_W-1:0]            link_data,
    input  logic                           link_vld,
    output logic                           link_credit,
    output logic [NIBBLE_W*NIBBLES-1:0]    out_data,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic                           frame_err,
    output logic                           ovf,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned CNT_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
`ifdef P2P_RX_PARITY_EN
    localparam int unsigned ASM_W = W;
`else
    localparam int unsigned ASM_W = W - NIBBLE_W;
`endif

    state_t              state;
    logic [CNT_W-1:0]    nib_cnt;
    logic [ASM_W-1:0]    asm_q;
`ifdef P2P_RX_PARITY_EN
    logic [NIBBLE_W-1:0] par_q;
`endif
    logic                done_c;
    logic [W-1:0]        word_c;
    logic                pop_c;
    logic                full;
    logic                empty;

    // Frame completion strobe and the word it delivers
    always_comb begin
        done_c = 1'b0;
`ifdef P2P_RX_PARITY_EN
        word_c = asm_q;
        done_c = link_vld && (state == CHECK) && (link_data == par_q);
`else
        word_c = {asm_q, link_data};
        done_c = link_vld && (state == DATA) && (nib_cnt == CNT_W'(NIBBLES - 1));
`endif
    end

    assign pop_c   = out_vld & out_rdy;
    assign out_vld = ~empty;

    // Deframer FSM with registered frame_err pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            nib_cnt   <= '0;
            asm_q     <= '0;
`ifdef P2P_RX_PARITY_EN
            par_q     <= '0;
`endif
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (link_vld) begin
                unique case (state)
                    IDLE: begin
                        if (link_data == SOF) begin
                            state   <= DATA;
                            nib_cnt <= '0;
`ifdef P2P_RX_PARITY_EN
                            par_q   <= '0;
`endif
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        asm_q   <= {asm_q[ASM_W-NIBBLE_W-1:0], link_data};
                        nib_cnt <= nib_cnt + CNT_W'(1);
`ifdef P2P_RX_PARITY_EN
                        par_q   <= nib_parity(par_q, link_data);
                        if (nib_cnt == CNT_W'(NIBBLES - 1)) state <= CHECK;
`else
                        if (nib_cnt == CNT_W'(NIBBLES - 1)) state <= IDLE;
`endif
                    end
`ifdef P2P_RX_PARITY_EN
                    CHECK: begin
                        if (link_data != par_q) frame_err <= 1'b1;
                        state <= IDLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Credit return and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            link_credit <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            link_credit <= pop_c;
            if (done_c && full && !pop_c) ovf <= 1'b1;
        end
    end

    p2p_rx_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (done_c),
        .din   (word_c),
        .pop   (pop_c),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_p2p_link_rx.sv
// Directed bench for p2p_link_rx; follows the P2P_RX_PARITY_EN setting of the build.
module tb_p2p_link_rx;

    logic        clk;
    logic        rst_n;
    logic [3:0]  link_data;
    logic        link_vld;
    logic        link_credit;
    logic [15:0] out_data;
    logic        out_vld;
    logic        out_rdy;
    logic        frame_err;
    logic        ovf;
    logic [2:0]  count;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [3:0]  data;
        logic        rdy;
        logic        e_vld;
        logic [15:0] e_data;
        logic        e_err;
        logic        e_cred;
        logic [2:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    p2p_link_rx #(.DEPTH(4), .NIBBLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .link_data   (link_data),
        .link_vld    (link_vld),
        .link_credit (link_credit),
        .out_data    (out_data),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .frame_err   (frame_err),
        .ovf         (ovf),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    function automatic void add(input logic r, input logic v, input logic [3:0] d, input logic rd,
                                input logic ev, input logic [15:0] ed, input logic ee,
                                input logic ec, input logic [2:0] en, input logic eo);
        vec_t x;
        x.rst_n = r; x.vld = v; x.data = d; x.rdy = rd;
        x.e_vld = ev; x.e_data = ed; x.e_err = ee; x.e_cred = ec; x.e_cnt = en; x.e_ovf = eo;
        vecs.push_back(x);
    endfunction

    function automatic void add_z(input logic r, input logic v, input logic [3:0] d, input logic rd);
        add(r, v, d, rd, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    endfunction

    // Drive one full frame; out_rdy is low except possibly on the final nibble
    task automatic send_frame(input logic [15:0] w, input logic last_rdy);
        logic [3:0] nb[$];
        logic [3:0] par;
        par = w[15:12] ^ w[11:8] ^ w[7:4] ^ w[3:0];
        nb.push_back(4'hA);
        for (int i = 0; i < 4; i++) nb.push_back(w[15-4*i -: 4]);
`ifdef P2P_RX_PARITY_EN
        nb.push_back(par);
`endif
        for (int i = 0; i < nb.size(); i++) begin
            link_vld  = 1'b1;
            link_data = nb[i];
            out_rdy   = (i == nb.size() - 1) ? last_rdy : 1'b0;
            step();
        end
        link_vld = 1'b0;
        out_rdy  = 1'b0;
    endtask

    // Pop the expected words in order, expecting a credit after every pop
    task automatic drain(input logic [15:0] exp_w[4]);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_vld%0d", i), 32'(out_vld), 32'd1);
            check($sformatf("drain_data%0d", i), 32'(out_data), 32'(exp_w[i]));
            out_rdy = 1'b1;
            step();
            check($sformatf("drain_credit%0d", i), 32'(link_credit), 32'd1);
        end
        out_rdy = 1'b0;
        step();
        check("drain_credit_end", 32'(link_credit), 32'd0);
        check("drain_count_end", 32'(count), 32'd0);
        check("drain_vld_end", 32'(out_vld), 32'd0);
    endtask

    initial begin
        logic [3:0]  nb[$];
        logic [15:0] exp_w[4];

        rst_n     = 1'b0;
        link_vld  = 1'b0;
        link_data = 4'h0;
        out_rdy   = 1'b0;

        // Reset state
        add_z(1'b0, 1'b0, 4'h0, 1'b0);

        // Good frame 1234, consumer ready
        add_z(1, 1, 4'hA, 1); add_z(1, 1, 4'h1, 1); add_z(1, 1, 4'h2, 1); add_z(1, 1, 4'h3, 1);
`ifdef P2P_RX_PARITY_EN
        add_z(1, 1, 4'h4, 1);
`endif
        add(1, 1, 4'h4, 1, 1, 16'h1234, 0, 0, 3'd1, 0);
        add(1, 0, 4'h0, 1, 0, 16'h0, 0, 1, 3'd0, 0);
        add_z(1, 0, 4'h0, 1);

`ifdef P2P_RX_PARITY_EN
        // Bad parity frame
        add_z(1, 1, 4'hA, 1); add_z(1, 1, 4'h1, 1); add_z(1, 1, 4'h2, 1);
        add_z(1, 1, 4'h3, 1); add_z(1, 1, 4'h4, 1);
        add(1, 1, 4'h5, 1, 0, 16'h0, 1, 0, 3'd0, 0);
        add_z(1, 0, 4'h0, 1);
`endif
        // Stray nibble in IDLE
        add(1, 1, 4'h7, 1, 0, 16'h0, 1, 0, 3'd0, 0);
        add_z(1, 0, 4'h0, 1);

        // Gapped frame, consumer stalled, then hold and pop
        nb = '{4'hA, 4'h1, 4'h2, 4'h3, 4'h4};
`ifdef P2P_RX_PARITY_EN
        nb.push_back(4'h4);
`endif
        for (int i = 0; i < nb.size(); i++) begin
            if (i == nb.size() - 1) begin
                add(1, 1, nb[i], 0, 1, 16'h1234, 0, 0, 3'd1, 0);
            end else begin
                add_z(1, 1, nb[i], 0);
                for (int g = 0; g < 3; g++) add_z(1, 0, 4'h0, 0);
            end
        end
        add(1, 0, 4'h0, 0, 1, 16'h1234, 0, 0, 3'd1, 0);
        add(1, 0, 4'h0, 1, 0, 16'h0, 0, 1, 3'd0, 0);
        add_z(1, 0, 4'h0, 0);

        // Reset mid-frame, then BEEF
        add_z(1, 1, 4'hA, 0); add_z(1, 1, 4'h1, 0); add_z(1, 1, 4'h2, 0);
        add_z(0, 0, 4'h0, 0);
        add_z(1, 1, 4'hA, 0); add_z(1, 1, 4'hB, 0); add_z(1, 1, 4'hE, 0); add_z(1, 1, 4'hE, 0);
`ifdef P2P_RX_PARITY_EN
        add_z(1, 1, 4'hF, 0);
        add(1, 1, 4'h4, 0, 1, 16'hBEEF, 0, 0, 3'd1, 0);
`else
        add(1, 1, 4'hF, 0, 1, 16'hBEEF, 0, 0, 3'd1, 0);
`endif
        add(1, 0, 4'h0, 1, 0, 16'h0, 0, 1, 3'd0, 0);
        add_z(1, 0, 4'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n     = vecs[i].rst_n;
            link_vld  = vecs[i].vld;
            link_data = vecs[i].data;
            out_rdy   = vecs[i].rdy;
            step();
            check($sformatf("v%0d_vld", i), 32'(out_vld), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld || !vecs[i].rst_n)
                check($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
            check($sformatf("v%0d_err", i), 32'(frame_err), 32'(vecs[i].e_err));
            check($sformatf("v%0d_credit", i), 32'(link_credit), 32'(vecs[i].e_cred));
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
        end

        // Fill to full, then complete a frame on the same edge as a pop
        rst_n = 1'b0; link_vld = 1'b0; out_rdy = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            send_frame(16'h1000 + 16'(k), 1'b0);
            check($sformatf("fill_count%0d", k), 32'(count), 32'(k));
            check($sformatf("fill_head%0d", k), 32'(out_data), 32'h1001);
            check($sformatf("fill_err%0d", k), 32'(frame_err), 32'd0);
            check($sformatf("fill_ovf%0d", k), 32'(ovf), 32'd0);
        end
        send_frame(16'h1005, 1'b1);
        check("fullpop_count", 32'(count), 32'd4);
        check("fullpop_ovf", 32'(ovf), 32'd0);
        check("fullpop_credit", 32'(link_credit), 32'd1);
        exp_w = '{16'h1002, 16'h1003, 16'h1004, 16'h1005};
        drain(exp_w);

        // Overflow: five frames into a four-deep FIFO with the consumer stalled
        for (int k = 1; k <= 5; k++) begin
            send_frame({4'(k), 4'(k), 4'(k), 4'(k)}, 1'b0);
            check($sformatf("ovf_count%0d", k), 32'(count), 32'((k > 4) ? 4 : k));
            check($sformatf("ovf_flag%0d", k), 32'(ovf), 32'((k == 5) ? 1 : 0));
        end
        exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        drain(exp_w);
        check("ovf_sticky", 32'(ovf), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/p2p_link_rx.md
# p2p_link_rx

Receiving end of the 4-bit point-to-point node link. Framed nibbles arrive from the peer node's transmitter. The block deframes them into 16-bit words, optionally checks a parity nibble, and buffers good words in a small FIFO for the local consumer. It returns one credit pulse to the transmitter per word drained, so the transmitter never sends more frames than there are free slots.

## Interface
- DEPTH, 4, FIFO depth in words; power of two, ≥2; also the transmitter's initial credit count
- NIBBLES, 4, data nibbles per frame; word width W = 4*NIBBLES
- Reset is synchronous and active-low. One clock.
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous active-low reset
- link_data  in  4  nibble from peer transmitter
- link_vld  in  1  link_data valid this cycle
- link_credit  out  1  one-cycle pulse per word popped
- out_data  out  W  head-of-FIFO word
- out_vld  out  1  FIFO non-empty
- out_rdy  in  1  consumer accepts out_data when out_vld & out_rdy
- frame_err  out  1  one-cycle pulse on a bad parity or a stray nibble
- ovf  out  1  sticky: a good frame was dropped because the FIFO was full
- count  out  $clog2(DEPTH+1)  words held

## Operation
- Frame: SOF nibble 4'hA, then NIBBLES data nibbles, MSB nibble first. With parity enabled, a final parity nibble follows, equal to the XOR of the data nibbles.
- A nibble is consumed only on an edge where link_vld=1. Gaps (link_vld=0) are allowed anywhere and hold all state.
- FSM states:
  - IDLE: a nibble equal to SOF moves to DATA and clears the nibble counter. Any other valid nibble is dropped and pulses frame_err.
  - DATA: each valid nibble shifts into the assembly register, MSB first, and the counter increments. Every nibble is treated as data, including 4'hA. On the NIBBLES-th nibble the FSM moves to CHECK if parity is enabled, otherwise it completes the frame and returns to IDLE.
  - CHECK: on a valid nibble, a match completes the frame. A mismatch pulses frame_err and drops the word. Either way the FSM returns to IDLE.
- Frame completion pushes the word into the FIFO on the same edge.
  - If the FIFO is full and no pop occurs on that edge, the word is dropped and ovf is set. Only reset clears ovf.
- Pop occurs on an edge where out_vld & out_rdy.
  - Push and pop on the same edge are both honoured, including when the FIFO is full. count is unchanged.
- link_credit is a registered copy of the pop strobe.
- Pointers are log2(DEPTH) bits and wrap naturally. count distinguishes full from empty.

## Timing
- Reset values: link_credit=0, out_vld=0, out_data=0, frame_err=0, ovf=0, count=0, FSM=IDLE, pointers=0.
- A reset asserted mid-frame discards the partial frame.
- Push latency: the final frame nibble is accepted on edge N. The word is visible on out_data with out_vld=1 after edge N. The FIFO is first-word-fall-through.
- Pop on edge P: link_credit is high for the cycle following P, then low. Back-to-back pops give a continuous high.
- frame_err is high for exactly one cycle, after the offending edge.
- out_data holds its value while out_vld=1 and out_rdy=0.

## Configuration
- P2P_RX_PARITY_EN
  - Defined: the frame carries a parity nibble, the CHECK state exists, and mismatches pulse frame_err.
  - Undefined: there is no parity nibble and no CHECK state. The frame completes on the last data nibble, and frame_err pulses only for stray nibbles in IDLE.
- The peer transmitter must be built with the same setting.

## Structure
- The shared package p2p_link_pkg holds:
  - SOF constant 4'hA
  - NIBBLE_W = 4
  - FSM state typedef (IDLE, DATA, CHECK)
  - the parity function
  - these are shared with the transmitter
- The sub-module p2p_rx_fifo implements the parameterised FWFT FIFO with push, pop, full, empty and count. The deframer FSM, credit register and status flags live in the top level.

## Test plan
- Frame A,1,2,3,4,4 (parity enabled), out_rdy=1 → out_data=16'h1234, out_vld high for one cycle, link_credit pulses once the cycle after the pop, frame_err=0.
- Frame A,1,2,3,4,5 → frame_err one-cycle pulse, count stays 0, no credit.
- Same good frame with link_vld=0 for 3 cycles between each nibble → out_data=16'h1234, identical result.
- DEPTH=4, out_rdy=0, five good frames → count=4, ovf=1 after the fifth. Then out_rdy=1 → words 1–4 drain in order, with four credit pulses.
- Nibbles A,1,2, then rst_n=0 for one cycle, then frame A,B,E,E,F,4 → only 16'hBEEF is delivered, with no frame_err.
- FIFO full, with a frame completing on the same edge as a pop → count stays 4, ovf stays 0, and the new word is last in order.
